// File: rtl/pc_sel_ctrl_pkg.sv
// rtl/pc_sel_ctrl_pkg.sv - shared encodings, counter constants and FSM states for the next-PC select logic
package pc_sel_ctrl_pkg;

  localparam logic [2:0] PCMUX_DEFAULT  = 3'd0;
  localparam logic [2:0] PCMUX_CURR_PC4 = 3'd1;
  localparam logic [2:0] PCMUX_PRED_TGT = 3'd2;
  localparam logic [2:0] PCMUX_BRANCH   = 3'd3;
  localparam logic [2:0] PCMUX_CORR_PC4 = 3'd4;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/pc_sel_ctrl_if.sv
// rtl/pc_sel_ctrl_if.sv - fetch lookup, EX resolve and next-PC control bundle
interface pc_sel_ctrl_if;

  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [2:0]  pc_sel;
  logic [31:0] predicted_target;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] corr_pc4;
  logic        flush;
  logic [15:0] mispredict_cnt;

  modport master (
    output fetch_valid, fetch_pc, ex_valid, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pc_sel, predicted_target, pred_taken, corr_pc4, flush, mispredict_cnt
  );

  modport slave (
    input  fetch_valid, fetch_pc, ex_valid, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pc_sel, predicted_target, pred_taken, corr_pc4, flush, mispredict_cnt
  );

endinterface

// File: rtl/pc_sel_ctrl_btb_table.sv
// rtl/pc_sel_ctrl_btb_table.sv - direct-mapped BTB storage with a one-deep update stage and read bypass
module btb_table #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [1:0]          rd_ctr,
  output logic [31:0]         rd_tgt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                wr_taken,
  input  logic [31:0]         wr_target
);
  import pc_sel_ctrl_pkg::*;

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]       valid_q;
  logic [ENTRIES-1:0][1:0]  ctr_q;
  logic [TAG_BITS-1:0]      tag_q [ENTRIES];
  logic [31:0]              tgt_q [ENTRIES];

  logic                upd_v_q;
  logic [IDX_BITS-1:0] upd_idx_q;
  logic [TAG_BITS-1:0] upd_tag_q;
  logic                upd_taken_q;
  logic [31:0]         upd_tgt_q;

  logic                upd_hit;
  logic                new_valid;
  logic [TAG_BITS-1:0] new_tag;
  logic [1:0]          new_ctr;
  logic [31:0]         new_tgt;
  logic                bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_v_q     <= 1'b0;
      upd_idx_q   <= '0;
      upd_tag_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_tgt_q   <= '0;
    end else begin
      upd_v_q <= wr_en;
      if (wr_en) begin
        upd_idx_q   <= wr_idx;
        upd_tag_q   <= wr_tag;
        upd_taken_q <= wr_taken;
        upd_tgt_q   <= wr_target;
      end
    end
  end

  // Entry as it will look once the pending update lands; feeds both the write and the bypass.
  always_comb begin
    upd_hit   = valid_q[upd_idx_q] && (tag_q[upd_idx_q] == upd_tag_q);
    new_valid = valid_q[upd_idx_q];
    new_tag   = tag_q[upd_idx_q];
    new_ctr   = ctr_q[upd_idx_q];
    new_tgt   = tgt_q[upd_idx_q];
    if (upd_hit) begin
      new_ctr = ctr_step(ctr_q[upd_idx_q], upd_taken_q);
      if (upd_taken_q) new_tgt = upd_tgt_q;
    end else if (upd_taken_q) begin
      new_valid = 1'b1;
      new_tag   = upd_tag_q;
      new_tgt   = upd_tgt_q;
      new_ctr   = CTR_WT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CTR_WNT}};
    end else if (upd_v_q) begin
      valid_q[upd_idx_q] <= new_valid;
      ctr_q[upd_idx_q]   <= new_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_v_q) begin
      tag_q[upd_idx_q] <= new_tag;
      tgt_q[upd_idx_q] <= new_tgt;
    end
  end

  assign bypass   = upd_v_q && (upd_idx_q == rd_idx);
  assign rd_valid = bypass ? new_valid : valid_q[rd_idx];
  assign rd_tag   = bypass ? new_tag   : tag_q[rd_idx];
  assign rd_ctr   = bypass ? new_ctr   : ctr_q[rd_idx];
  assign rd_tgt   = bypass ? new_tgt   : tgt_q[rd_idx];

endmodule

// File: rtl/pc_sel_ctrl.sv
// rtl/pc_sel_ctrl.sv - BTB lookup, mispredict resolve, next-PC select priority and front-end flush FSM
module pc_sel_ctrl #(
  parameter int IDX_BITS  = 4,
  parameter int TAG_BITS  = 8,
  parameter int FLUSH_CYC = 2
) (
  input logic          clk,
  input logic          rst_n,
  pc_sel_ctrl_if.slave bus
);
  import pc_sel_ctrl_pkg::*;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC);

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic [TAG_BITS-1:0] ex_tag;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [1:0]          rd_ctr;
  logic [31:0]         rd_tgt;

  logic        hit;
  logic        lk_taken;
  logic [31:0] lk_tgt;
  logic        mis_nt;
  logic        mis_t;
  logic        mis_any;
  logic [31:0] ex_pc4;

  fsm_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] corr_q;
  logic [15:0] mis_cnt_q;

  logic [2:0]  pc_sel;
  logic        pred_taken;
  logic [31:0] corr_pc4;
  logic        flush;

  // Low two PC bits are dropped by the shift; bits above the tag are ignored.
  assign f_idx  = IDX_BITS'(bus.fetch_pc >> 2);
  assign f_tag  = TAG_BITS'(bus.fetch_pc >> (IDX_BITS + 2));
  assign ex_idx = IDX_BITS'(bus.ex_pc >> 2);
  assign ex_tag = TAG_BITS'(bus.ex_pc >> (IDX_BITS + 2));
  assign ex_pc4 = bus.ex_pc + 32'd4;

  btb_table #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (f_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_ctr    (rd_ctr),
    .rd_tgt    (rd_tgt),
    .wr_en     (bus.ex_valid),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_taken  (bus.ex_taken),
    .wr_target (bus.ex_target)
  );

  assign hit      = rd_valid && (rd_tag == f_tag);
  assign lk_taken = hit && rd_ctr[1];
  assign lk_tgt   = hit ? rd_tgt : 32'd0;

  assign mis_nt  = bus.ex_valid && bus.ex_taken &&
                   (!bus.ex_pred_taken || (bus.ex_pred_target != bus.ex_target));
  assign mis_t   = bus.ex_valid && !bus.ex_taken && bus.ex_pred_taken;
  assign mis_any = mis_nt || mis_t;
  assign flush   = (state_q == ST_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mispredict in any state (re)loads the flush window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mis_any) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else if (state_q == ST_FLUSH) begin
      if (cnt_q <= 2'd1) begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_comb begin
    pc_sel     = PCMUX_CURR_PC4;
    pred_taken = lk_taken && !flush;
    corr_pc4   = corr_q;
    if (mis_nt) begin
      pc_sel = PCMUX_BRANCH;
    end else if (mis_t) begin
      pc_sel   = PCMUX_CORR_PC4;
      corr_pc4 = ex_pc4;
    end else if (flush) begin
      pc_sel = PCMUX_CURR_PC4;
    end else if (bus.fetch_valid && lk_taken) begin
      pc_sel = PCMUX_PRED_TGT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q    <= 32'd0;
      mis_cnt_q <= 16'd0;
    end else begin
      if (bus.ex_valid) corr_q <= ex_pc4;
      if (mis_any && (mis_cnt_q != 16'hFFFF)) mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign bus.pc_sel           = pc_sel;
  assign bus.predicted_target = lk_tgt;
  assign bus.pred_taken       = pred_taken;
  assign bus.corr_pc4         = corr_pc4;
  assign bus.flush            = flush;
  assign bus.mispredict_cnt   = mis_cnt_q;

endmodule

// File: tb/tb_pc_sel_ctrl.sv
// tb/tb_pc_sel_ctrl.sv - directed and randomized check of pc_sel_ctrl against a table-level model
module tb_pc_sel_ctrl;
  import pc_sel_ctrl_pkg::*;

  localparam int ENT       = 16;
  localparam int FLUSH_CYC = 2;
  localparam logic [31:0] ALIAS = 32'h0000_1100;

  typedef struct {
    bit          v;
    int unsigned tag;
    int          ctr;
    logic [31:0] tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sel_ctrl_if bus();

  pc_sel_ctrl #(.IDX_BITS(4), .TAG_BITS(8), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  ent_t        m_tab [ENT];
  bit          pend_v;
  int unsigned pend_idx, pend_tag;
  bit          pend_taken;
  logic [31:0] pend_tgt;
  int          flush_left;
  int unsigned m_cnt;
  logic [31:0] m_corr;

  logic [2:0]  last_sel;
  logic        last_pt, last_flush;
  logic [31:0] last_tgt, last_corr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned pc_idx(input logic [31:0] pc);
    return (pc >> 2) % ENT;
  endfunction

  function automatic int unsigned pc_tag(input logic [31:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic ent_t merged(input ent_t e);
    ent_t r = e;
    if (e.v && e.tag == pend_tag) begin
      if (pend_taken) begin
        r.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
        r.tgt = pend_tgt;
      end else begin
        r.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
      end
    end else if (pend_taken) begin
      r.v = 1; r.tag = pend_tag; r.tgt = pend_tgt; r.ctr = 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_tab[i].v = 0; m_tab[i].tag = 0; m_tab[i].ctr = 1; m_tab[i].tgt = 0;
    end
    pend_v = 0; flush_left = 0; m_cnt = 0; m_corr = 0;
  endtask

  task automatic cyc(input bit fv, input logic [31:0] fpc, input bit ev, input logic [31:0] epc,
                     input bit et, input logic [31:0] etg, input bit ept, input logic [31:0] eptg);
    ent_t e;
    bit hit, e_flush, e_pt, mnt, mt;
    logic [2:0] e_sel;
    logic [31:0] e_tgt, e_corr;
    bus.fetch_valid = fv; bus.fetch_pc = fpc;
    bus.ex_valid = ev; bus.ex_pc = epc; bus.ex_taken = et; bus.ex_target = etg;
    bus.ex_pred_taken = ept; bus.ex_pred_target = eptg;
    @(negedge clk);
    e = m_tab[pc_idx(fpc)];
    if (pend_v && pend_idx == pc_idx(fpc)) e = merged(e);
    hit     = e.v && (e.tag == pc_tag(fpc));
    e_flush = flush_left > 0;
    e_pt    = hit && (e.ctr >= 2) && !e_flush;
    e_tgt   = hit ? e.tgt : 32'd0;
    mnt     = ev && et && (!ept || eptg != etg);
    mt      = ev && !et && ept;
    e_sel   = mnt ? PCMUX_BRANCH : mt ? PCMUX_CORR_PC4 : e_flush ? PCMUX_CURR_PC4 :
              (fv && e_pt) ? PCMUX_PRED_TGT : PCMUX_CURR_PC4;
    e_corr  = mt ? epc + 32'd4 : m_corr;
    last_sel = bus.pc_sel; last_pt = bus.pred_taken; last_flush = bus.flush;
    last_tgt = bus.predicted_target; last_corr = bus.corr_pc4;
    check("pc_sel", 32'(last_sel), 32'(e_sel));
    check("pred_taken", 32'(last_pt), 32'(e_pt));
    check("pred_target", last_tgt, e_tgt);
    check("flush", 32'(last_flush), 32'(e_flush));
    check("corr_pc4", last_corr, e_corr);
    check("mis_cnt", 32'(bus.mispredict_cnt), m_cnt);
    if (pend_v) m_tab[pend_idx] = merged(m_tab[pend_idx]);
    pend_v = ev; pend_idx = pc_idx(epc); pend_tag = pc_tag(epc); pend_taken = et; pend_tgt = etg;
    if (ev) m_corr = epc + 32'd4;
    if (mnt || mt) begin
      flush_left = FLUSH_CYC;
      if (m_cnt < 65535) m_cnt++;
    end else if (flush_left > 0) begin
      flush_left--;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
  endtask

  task automatic do_reset();
    bus.fetch_valid = 1; bus.fetch_pc = 32'h100; bus.ex_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
    check("rst_corr", bus.corr_pc4, 32'd0);
    check("rst_sel", 32'(bus.pc_sel), 32'(PCMUX_CURR_PC4));
    check("rst_pt", 32'(bus.pred_taken), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] r = $urandom;
    return (r & 32'hFFFF_C003) | (32'($urandom_range(0, 1)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    model_reset();
    rst_n = 0;
    bus.fetch_valid = 1; bus.fetch_pc = 32'h100; bus.ex_valid = 0; bus.ex_pc = 0;
    bus.ex_taken = 0; bus.ex_target = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_sel", 32'(bus.pc_sel), 32'(PCMUX_CURR_PC4));
    check("init_flush", 32'(bus.flush), 32'd0);
    rst_n = 1;

    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("t1_sel", 32'(last_sel), 32'(PCMUX_CURR_PC4));
    check("t1_pt", 32'(last_pt), 32'd0);

    cyc(1, 32'h300, 1, 32'h100, 1, 32'h200, 0, 0);
    check("t2_branch", 32'(last_sel), 32'(PCMUX_BRANCH));
    idle(1); check("t2_flush1", 32'(last_flush), 32'd1);
    idle(1); check("t2_flush2", 32'(last_flush), 32'd1);
    idle(1); check("t2_flush_end", 32'(last_flush), 32'd0);
    check("t2_cnt", 32'(bus.mispredict_cnt), 32'd1);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("t2_pred", 32'(last_sel), 32'(PCMUX_PRED_TGT));
    check("t2_tgt", last_tgt, 32'h200);

    cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200);
    cyc(0, 0, 1, 32'h100, 0, 0, 1, 32'h200);
    check("t3_corr_sel", 32'(last_sel), 32'(PCMUX_CORR_PC4));
    check("t3_corr", last_corr, 32'h104);
    idle(2);
    cyc(0, 0, 1, 32'h100, 0, 0, 1, 32'h200);
    idle(2);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("t3_weak", 32'(last_sel), 32'(PCMUX_CURR_PC4));
    cyc(0, 0, 1, 32'h100, 0, 0, 1, 32'h200);
    idle(2);

    cyc(1, ALIAS, 0, 0, 0, 0, 0, 0);
    check("t4_alias_miss", 32'(last_sel), 32'(PCMUX_CURR_PC4));
    cyc(0, 0, 1, ALIAS, 1, 32'h900, 0, 0);
    idle(2);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("t4_old_gone", last_tgt, 32'd0);
    cyc(1, ALIAS, 0, 0, 0, 0, 0, 0);
    check("t4_alias_tgt", last_tgt, 32'h900);

    cyc(1, ALIAS, 1, 32'h308, 1, 32'h500, 0, 0);
    check("t5_branch_wins", 32'(last_sel), 32'(PCMUX_BRANCH));
    idle(2);
    cyc(0, 0, 1, ALIAS, 1, 32'hA00, 1, 32'hA00);
    cyc(1, ALIAS, 0, 0, 0, 0, 0, 0);
    check("t5_bypass_tgt", last_tgt, 32'hA00);
    check("t5_bypass_sel", 32'(last_sel), 32'(PCMUX_PRED_TGT));

    cyc(0, 0, 1, 32'h400, 1, 32'h600, 0, 0);
    cyc(0, 0, 1, 32'h440, 0, 0, 1, 32'h0);
    check("t6_flush_c1", 32'(last_flush), 32'd1);
    idle(1); check("t6_ext1", 32'(last_flush), 32'd1);
    idle(1); check("t6_ext2", 32'(last_flush), 32'd1);
    idle(1); check("t6_ext_end", 32'(last_flush), 32'd0);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h0);
    check("wrap_corr", last_corr, 32'd0);
    cyc(0, 0, 1, 32'h500, 1, 32'h700, 0, 0);
    check("t6_mid_flush", 32'(last_flush), 32'd1);
    do_reset();
    cyc(1, 32'h400, 0, 0, 0, 0, 0, 0);
    check("t6_tbl_clear", last_tgt, 32'd0);
    cyc(1, 32'h500, 0, 0, 0, 0, 0, 0);
    check("t6_pend_drop", last_tgt, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t0, t1;
      t0 = 32'h8000 | (32'($urandom_range(0, 3)) << 4);
      t1 = 32'h8000 | (32'($urandom_range(0, 3)) << 4);
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, rnd_pc(), $urandom_range(0, 9) < 4, rnd_pc(),
          $urandom_range(0, 1) == 1, t0, $urandom_range(0, 1) == 1, t1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
